// File: rtl/lcd_char_driver.sv
// HD44780 16x2 character LCD driver, 4-bit write-only mode.
// Runs the power-up init sequence, then refreshes both lines forever from a per-frame snapshot of chars.
module lcd_char_driver #(
  parameter int PWR_CYC   = 750000,
  parameter int INIT_CYC  = 205000,
  parameter int SETUP_CYC = 2,
  parameter int E_CYC     = 12,
  parameter int NIB_CYC   = 50,
  parameter int CMD_CYC   = 2000,
  parameter int CLR_CYC   = 82000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] chars,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_e,
  output logic         lcd_4,
  output logic         lcd_5,
  output logic         lcd_6,
  output logic         lcd_7,
  output logic         frame_done
);

  localparam int MAX_A   = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
  localparam int MAX_CYC = (MAX_A > INIT_CYC) ? MAX_A : INIT_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_PWR   = CW'(PWR_CYC);
  localparam logic [CW-1:0] C_INIT  = CW'(INIT_CYC);
  localparam logic [CW-1:0] C_SETUP = CW'(SETUP_CYC);
  localparam logic [CW-1:0] C_E     = CW'(E_CYC);
  localparam logic [CW-1:0] C_NIB   = CW'(NIB_CYC);
  localparam logic [CW-1:0] C_CMD   = CW'(CMD_CYC);
  localparam logic [CW-1:0] C_CLR   = CW'(CLR_CYC);

  typedef enum logic [2:0] {
    S_PWR, S_INIT, S_CFG, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2, S_DONE
  } state_t;

  typedef enum logic [1:0] {PH_WAIT, PH_SETUP, PH_EHI} phase_t;

  state_t        r_st, w_st_n;
  phase_t        r_ph, w_ph_n;
  logic [1:0]    r_step, w_step_n;
  logic [4:0]    r_idx, w_idx_n;
  logic          r_lo, w_lo_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [255:0]  r_snap;
  logic          r_rs, r_e, r_done;
  logic [3:0]    r_data;
  logic [4:0]    w_pos;
  logic [7:0]    w_byte;
  logic [3:0]    w_nib;
  logic          w_rs;

  // r_cnt counts the cycles left in the current phase; a phase ends on the cycle it reads 1.
  // r_lo doubles as "next wait is the post-wait" so the nibble gap and post-wait share PH_WAIT.
  always_comb begin
    w_st_n   = r_st;
    w_ph_n   = r_ph;
    w_step_n = r_step;
    w_idx_n  = r_idx;
    w_lo_n   = r_lo;
    w_cnt_n  = r_cnt - C_ONE;
    if (r_cnt == C_ONE) begin
      w_cnt_n = C_SETUP;
      unique case (r_ph)
        PH_SETUP: begin
          w_ph_n  = PH_EHI;
          w_cnt_n = C_E;
        end
        PH_EHI: begin
          w_ph_n = PH_WAIT;
          if (r_st == S_INIT) begin
            w_lo_n  = 1'b1;
            w_cnt_n = (r_step == 2'd0) ? C_INIT : C_CMD;
          end else if (!r_lo) begin
            w_cnt_n = C_NIB;
          end else begin
            w_cnt_n = (r_st == S_CFG && r_step == 2'd3) ? C_CLR : C_CMD;
          end
        end
        default: begin
          w_ph_n = PH_SETUP;
          w_lo_n = 1'b0;
          if (r_st == S_PWR) begin
            w_st_n   = S_INIT;
            w_step_n = 2'd0;
          end else if (r_st == S_DONE) begin
            w_st_n = S_ADDR1;
          end else if (!r_lo) begin
            w_lo_n = 1'b1;
          end else begin
            case (r_st)
              S_INIT: begin
                if (r_step == 2'd3) begin
                  w_st_n   = S_CFG;
                  w_step_n = 2'd0;
                end else begin
                  w_step_n = r_step + 2'd1;
                end
              end
              S_CFG: begin
                if (r_step == 2'd3) w_st_n = S_ADDR1;
                else                w_step_n = r_step + 2'd1;
              end
              S_ADDR1: begin
                w_st_n  = S_LINE1;
                w_idx_n = 5'd0;
              end
              S_LINE1: begin
                if (r_idx == 5'd15) w_st_n = S_ADDR2;
                else                w_idx_n = r_idx + 5'd1;
              end
              S_ADDR2: begin
                w_st_n  = S_LINE2;
                w_idx_n = 5'd0;
              end
              S_LINE2: begin
                if (r_idx == 5'd15) begin
                  w_st_n  = S_DONE;
                  w_ph_n  = PH_WAIT;
                  w_cnt_n = C_ONE;
                end else begin
                  w_idx_n = r_idx + 5'd1;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // Nibble for the item about to start; bit address of character pos is 255-8*pos = {~pos,3'b111}.
  always_comb begin
    w_pos  = w_idx_n | {(w_st_n == S_LINE2), 4'b0000};
    w_rs   = 1'b0;
    w_byte = 8'h00;
    case (w_st_n)
      S_CFG: begin
        case (w_step_n)
          2'd0:    w_byte = 8'h28;
          2'd1:    w_byte = 8'h06;
          2'd2:    w_byte = 8'h0C;
          default: w_byte = 8'h01;
        endcase
      end
      S_ADDR1: w_byte = 8'h80;
      S_ADDR2: w_byte = 8'hC0;
      S_LINE1, S_LINE2: begin
        w_rs   = 1'b1;
        w_byte = r_snap[{~w_pos, 3'b111} -: 8];
      end
      default: ;
    endcase
    if (w_st_n == S_INIT) w_nib = (w_step_n == 2'd3) ? 4'h2 : 4'h3;
    else                  w_nib = w_lo_n ? w_byte[3:0] : w_byte[7:4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= S_PWR;
      r_ph   <= PH_WAIT;
      r_step <= 2'd0;
      r_idx  <= 5'd0;
      r_lo   <= 1'b0;
      r_cnt  <= C_PWR;
      r_snap <= '0;
      r_rs   <= 1'b0;
      r_data <= 4'h0;
      r_e    <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_st   <= w_st_n;
      r_ph   <= w_ph_n;
      r_step <= w_step_n;
      r_idx  <= w_idx_n;
      r_lo   <= w_lo_n;
      r_cnt  <= w_cnt_n;
      if (w_st_n == S_ADDR1 && r_st != S_ADDR1) r_snap <= chars;
      // RS/data only move at setup start so they stay put through E and the following wait.
      if (w_ph_n == PH_SETUP && r_ph != PH_SETUP) begin
        r_rs   <= w_rs;
        r_data <= w_nib;
      end
      r_e    <= (w_ph_n == PH_EHI);
      r_done <= (w_st_n == S_DONE);
    end
  end

  assign lcd_rs     = r_rs;
  assign lcd_rw     = 1'b0;
  assign lcd_e      = r_e;
  assign lcd_4      = r_data[0];
  assign lcd_5      = r_data[1];
  assign lcd_6      = r_data[2];
  assign lcd_7      = r_data[3];
  assign frame_done = r_done;

endmodule

// File: tb/tb_lcd_char_driver.sv
// Bench for lcd_char_driver: a bus monitor captures each nibble on the E fall and checks it,
// plus E timing, gaps and frame_done cycles, against a queue filled from the command-level model.
module tb_lcd_char_driver;

  localparam int PWR   = 20;
  localparam int INIT  = 10;
  localparam int SETUP = 2;
  localparam int E     = 3;
  localparam int NIB   = 4;
  localparam int CMD   = 6;
  localparam int CLR   = 15;

  localparam int BP         = 2 * (SETUP + E) + NIB + CMD;
  localparam int INIT_T     = 4 * (SETUP + E) + INIT + 3 * CMD;
  localparam int CFG_T      = 4 * BP - CMD + CLR;
  localparam int T0         = PWR + INIT_T + CFG_T;
  localparam int FP         = 34 * BP + 1;
  localparam int FIRST_DONE = T0 + 34 * BP;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] chars = '0;
  logic         lcd_rs, lcd_rw, lcd_e, lcd_4, lcd_5, lcd_6, lcd_7, frame_done;

  lcd_char_driver #(
    .PWR_CYC(PWR), .INIT_CYC(INIT), .SETUP_CYC(SETUP), .E_CYC(E),
    .NIB_CYC(NIB), .CMD_CYC(CMD), .CLR_CYC(CLR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .chars(chars),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_4(lcd_4), .lcd_5(lcd_5), .lcd_6(lcd_6), .lcd_7(lcd_7),
    .frame_done(frame_done)
  );

  // ---------------- clock / reset-relative cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  // Entry: [31]=frame_done marker; nibble: [19:8] fall-to-next-rise gap, [4] rs, [3:0] nibble;
  // marker: [23:0] expected frame_done cycle.
  logic [31:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (command level) ----------------
  task automatic push_nib(input logic rs, input logic [3:0] nib, input int gap);
    logic [11:0] g;
    g = gap[11:0];
    exp_q.push_back({1'b0, 11'd0, g, 3'b000, rs, nib});
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b, input int post, input int extra);
    push_nib(rs, b[7:4], NIB + SETUP);
    push_nib(rs, b[3:0], post + SETUP + extra);
  endtask

  task automatic push_init_cfg();
    push_nib(1'b0, 4'h3, INIT + SETUP);
    push_nib(1'b0, 4'h3, CMD + SETUP);
    push_nib(1'b0, 4'h3, CMD + SETUP);
    push_nib(1'b0, 4'h2, CMD + SETUP);
    push_byte(1'b0, 8'h28, CMD, 0);
    push_byte(1'b0, 8'h06, CMD, 0);
    push_byte(1'b0, 8'h0C, CMD, 0);
    push_byte(1'b0, 8'h01, CLR, 0);
  endtask

  // The last data byte's gap also spans the single DONE cycle before the next frame's 0x80.
  task automatic push_frame(input logic [255:0] d, input int done_cyc);
    logic [23:0] dc;
    push_byte(1'b0, 8'h80, CMD, 0);
    for (int i = 0; i < 32; i++) begin
      if (i == 16) push_byte(1'b0, 8'hC0, CMD, 0);
      push_byte(1'b1, d[255 - 8 * i -: 8], CMD, (i == 31) ? 1 : 0);
    end
    dc = done_cyc[23:0];
    exp_q.push_back({1'b1, 7'd0, dc});
  endtask

  // ---------------- monitor ----------------
  logic [4:0]  bus, prev_bus;
  logic        prev_e, prev_done, have_gap;
  int          rise_cyc, fall_cyc, last_chg, nrise, exp_gap;
  logic [31:0] ent;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_e    = 1'b0;
      prev_done = 1'b0;
      prev_bus  = 5'd0;
      have_gap  = 1'b0;
      nrise     = 0;
      last_chg  = 0;
    end else begin
      bus = {lcd_rs, lcd_7, lcd_6, lcd_5, lcd_4};
      if (cyc < PWR + SETUP) chk("pwr_e_low", int'(lcd_e), 0);
      if (cyc < PWR) chk("pwr_bus_zero", int'(bus), 0);
      if (prev_e && lcd_e) chk("bus_stable_e_high", int'(bus), int'(prev_bus));
      if (bus != prev_bus) last_chg = cyc;
      if (lcd_e && !prev_e) begin
        chk("setup_time", int'(cyc - last_chg >= SETUP), 1);
        chk("rw_low", int'(lcd_rw), 0);
        if (nrise == 0) begin
          chk("first_e_rise_cycle", cyc, PWR + SETUP);
          chk("first_nibble", int'(bus), 5'h03);
        end else if (have_gap) begin
          chk("gap_cycles", cyc - fall_cyc, exp_gap);
        end
        rise_cyc = cyc;
        nrise++;
      end
      if (!lcd_e && prev_e) begin
        chk("e_high_width", cyc - rise_cyc, E);
        chk("nibble_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          ent = exp_q.pop_front();
          chk("nibble_not_done", int'(ent[31]), 0);
          chk("nibble_value", int'(bus), int'(ent[4:0]));
          exp_gap  = int'(ent[19:8]);
          have_gap = 1'b1;
          fall_cyc = cyc;
        end
      end
      if (prev_done) chk("done_width", int'(frame_done), 0);
      if (frame_done && !prev_done) begin
        chk("done_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          ent = exp_q.pop_front();
          chk("done_order", int'(ent[31]), 1);
          chk("done_cycle", cyc, int'(ent[23:0]));
        end
      end
      prev_e    = lcd_e;
      prev_done = frame_done;
      prev_bus  = bus;
    end
  end

  // ---------------- driver ----------------
  logic [127:0] line1, line2;
  int           guard;

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    line1 = "         HCMUTE ";
    line2 = "  05 - 05 - 2015";
    chars = {line1, line2};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({lcd_rs, lcd_rw, lcd_e, lcd_7, lcd_6, lcd_5, lcd_4, frame_done}), 0);

    push_init_cfg();
    push_frame(chars, FIRST_DONE);
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-LINE1 change: current frame keeps the snapshot, next frame shows all 'A'.
    wait_cyc(T0 + 300);
    chars = {32{8'h41}};
    push_frame(chars, FIRST_DONE + FP);

    for (int f = 1; f <= 4; f++) begin
      wait_cyc(T0 + f * FP + 300);
      chars = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      push_frame(chars, FIRST_DONE + (f + 1) * FP);
    end

    // Async reset while E is high, away from any clock edge.
    wait_cyc(T0 + 5 * FP + 200);
    guard = 0;
    while (!lcd_e && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("e_high_before_reset", int'(lcd_e), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_e_drop", int'(lcd_e), 0);
    chk("async_outputs_zero", int'({lcd_rs, lcd_rw, lcd_e, lcd_7, lcd_6, lcd_5, lcd_4, frame_done}), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);

    push_init_cfg();
    push_frame(chars, FIRST_DONE);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(FIRST_DONE + 2);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
